// File: rtl/div_sequencer_if.sv
// -----------------------------------------------------------------------------
// div_sequencer_if
// Handshake and operand bundle between the execute stage and the divide
// sequencer.
//   start    : request, sampled by the sequencer only while it is idle
//   op       : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend : rs1 operand
//   divisor  : rs2 operand
//   busy     : sequencer is working, the pipeline must stall
//   done     : one-cycle pulse, result valid
//   result   : quotient or remainder, held until the next done
// The master modport is the requester (pipeline); the slave is the sequencer.
// -----------------------------------------------------------------------------
interface div_sequencer_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] result;

   modport master (
      output start, op, dividend, divisor,
      input  busy, done, result
   );

   modport slave (
      input  start, op, dividend, divisor,
      output busy, done, result
   );
endinterface

// File: rtl/div_sequencer.sv
// -----------------------------------------------------------------------------
// div_sequencer
// Multi-cycle restoring divider for RISC-V DIV/DIVU/REM/REMU. One 32-bit
// subtractor is reused for 32 trial subtractions; sign handling and the
// divide-by-zero / signed-overflow results are applied around the loop.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : div_sequencer_if slave (start/op/operands in, busy/done/result out)
// Parameter SPECIAL_FAST: 1 = divide-by-zero and overflow skip the loop.
// busy/done/result are registered from the current state, so they appear one
// clock after the state that produces them; done therefore coincides with the
// first idle cycle, and start is refused while done is high so that the done
// cycle still behaves as part of the operation.
// -----------------------------------------------------------------------------
module div_sequencer #(
   parameter bit SPECIAL_FAST = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   div_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_ITER = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // Forced result for divide-by-zero (dz=1) or signed overflow (dz=0).
   function automatic logic [31:0] special_result(input logic [1:0]  op,
                                                  input logic        dz,
                                                  input logic [31:0] dividend);
      logic [31:0] res;
      if (dz) begin
         res = op[1] ? dividend : 32'hFFFF_FFFF;
      end else begin
         res = op[1] ? 32'h0000_0000 : 32'h8000_0000;
      end
      return res;
   endfunction

   state_t      state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [31:0] a_q, a_d;        // original dividend
   logic [31:0] dvs_q, dvs_d;    // divisor, later its magnitude
   logic [31:0] q_q, q_d;
   logic [31:0] r_q, r_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        qneg_q, qneg_d;
   logic        rneg_q, rneg_d;
   logic        dz_q, dz_d;
   logic        ovf_q, ovf_d;
   logic [31:0] res_q, res_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [31:0] result_q, result_d;

   logic        is_signed;
   logic [31:0] mag_a, mag_b;
   logic        msb_out;
   logic [31:0] r_shift, q_shift;
   logic [32:0] sub_res;
   logic        accept;
   logic [31:0] q_fix, r_fix;

   // Shared datapath: operand magnitudes, shifted partial remainder, trial subtract.
   always_comb begin
      is_signed = ~op_q[0];
      mag_a     = (is_signed && a_q[31])   ? (32'd0 - a_q)   : a_q;
      mag_b     = (is_signed && dvs_q[31]) ? (32'd0 - dvs_q) : dvs_q;
      msb_out   = r_q[31];
      r_shift   = {r_q[30:0], q_q[31]};
      q_shift   = {q_q[30:0], 1'b0};
      sub_res   = {1'b0, r_shift} - {1'b0, dvs_q};
      // A set bit shifted out of R means the partial remainder exceeds any divisor.
      accept    = msb_out | ~sub_res[32];
      q_fix     = qneg_q ? (32'd0 - q_q) : q_q;
      r_fix     = rneg_q ? (32'd0 - r_q) : r_q;
   end

   // Next-state and next-output computation for the sequencer.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      dvs_d    = dvs_q;
      q_d      = q_q;
      r_d      = r_q;
      cnt_d    = cnt_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      dz_d     = dz_q;
      ovf_d    = ovf_q;
      res_d    = res_q;
      busy_d   = (state_q != S_IDLE);
      done_d   = (state_q == S_DONE);
      if (state_q == S_DONE) begin
         result_d = res_q;
      end else begin
         result_d = result_q;
      end

      case (state_q)
         S_IDLE: begin
            if (bus.start && !done_q) begin
               op_d    = bus.op;
               a_d     = bus.dividend;
               dvs_d   = bus.divisor;
               state_d = S_PREP;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_PREP: begin
            qneg_d = is_signed & (a_q[31] ^ dvs_q[31]);
            rneg_d = is_signed & a_q[31];
            dz_d   = (dvs_q == 32'd0);
            ovf_d  = is_signed && (a_q == 32'h8000_0000) && (dvs_q == 32'hFFFF_FFFF);
            q_d    = mag_a;
            r_d    = 32'd0;
            cnt_d  = 5'd0;
            dvs_d  = mag_b;
            if (SPECIAL_FAST && ((dvs_q == 32'd0) || (is_signed && (a_q == 32'h8000_0000)
                                                   && (dvs_q == 32'hFFFF_FFFF)))) begin
               res_d   = special_result(op_q, (dvs_q == 32'd0), a_q);
               state_d = S_DONE;
            end else begin
               state_d = S_ITER;
            end
         end
         S_ITER: begin
            if (accept) begin
               r_d = sub_res[31:0];
            end else begin
               r_d = r_shift;
            end
            q_d = {q_shift[31:1], accept};
            if (cnt_q == 5'd31) begin
               state_d = S_FIX;
            end else begin
               cnt_d   = cnt_q + 5'd1;
               state_d = S_ITER;
            end
         end
         S_FIX: begin
            if (dz_q || ovf_q) begin
               res_d = special_result(op_q, dz_q, a_q);
            end else begin
               res_d = op_q[1] ? r_fix : q_fix;
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, datapath and output registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= 2'd0;
         a_q      <= 32'd0;
         dvs_q    <= 32'd0;
         q_q      <= 32'd0;
         r_q      <= 32'd0;
         cnt_q    <= 5'd0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         ovf_q    <= 1'b0;
         res_q    <= 32'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         dvs_q    <= dvs_d;
         q_q      <= q_d;
         r_q      <= r_d;
         cnt_q    <= cnt_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         dz_q     <= dz_d;
         ovf_q    <= ovf_d;
         res_q    <= res_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;

endmodule
